// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-fetch path.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS = 1024;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {pc, instr} buffer that parks a fetched word while decode stalls.
module if_hold_buf
  import riscv_pkg::*;
#(
  parameter int unsigned W = riscv_pkg::XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_instr,
  output logic         q_valid,
  output logic [W-1:0] q_pc,
  output logic [W-1:0] q_instr
);

  logic         valid_q, valid_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = d_pc;
      instr_d = d_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign q_valid = valid_q;
  assign q_pc    = pc_q;
  assign q_instr = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: owns the PC, drives i_mem and hands {pc, instr} to decode
// under a valid/stall handshake, with redirects from execute.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned       XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign_err
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            misalign_q, misalign_d;

  logic            hold_load, hold_clear;
  logic            hold_valid;
  logic [XLEN-1:0] hold_pc, hold_instr;

  if_hold_buf #(
    .W (XLEN)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .clear   (hold_clear),
    .d_pc    (rsp_pc_q),
    .d_instr (imem_instr),
    .q_valid (hold_valid),
    .q_pc    (hold_pc),
    .q_instr (hold_instr)
  );

  always_comb begin
    pc_d        = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    misalign_d  = 1'b0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_valid_d = 1'b0;
      hold_clear  = 1'b1;
      misalign_d  = |redirect_pc[1:0];
    end else if (stall) begin
      // The re-read of pc_q is dropped; a word already in flight is parked instead.
      rsp_valid_d = 1'b0;
      rsp_pc_d    = pc_q;
      hold_load   = rsp_valid_q & ~hold_valid;
    end else begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = pc_q;
      pc_d        = pc_q + XLEN'(PC_STEP);
      hold_clear  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    if_valid = 1'b0;
    if_pc    = '0;
    if_instr = '0;
    if (hold_valid) begin
      if_valid = 1'b1;
      if_pc    = hold_pc;
      if_instr = hold_instr;
    end else if (rsp_valid_q) begin
      if_valid = 1'b1;
      if_pc    = rsp_pc_q;
      if_instr = imem_instr;
    end
  end

  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised scoreboard bench for if_fetch_unit: a sequential-stream reference model
// predicts accepted {pc, instr}; a negedge monitor compares what the DUT presents.
module tb_if_fetch_unit;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect_valid, if_valid, misalign_err;
  logic [31:0] redirect_pc, imem_addr, imem_instr, if_pc, if_instr;

  logic        rst2_n, if_valid2, misalign_err2;
  logic [31:0] imem_addr2, imem_instr2, if_pc2, if_instr2;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  if_fetch_unit #(
    .RESET_PC (WRAP_PC)
  ) dut_wrap (
    .clk            (clk),
    .rst_n          (rst2_n),
    .imem_addr      (imem_addr2),
    .imem_instr     (imem_instr2),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (if_valid2),
    .if_pc          (if_pc2),
    .if_instr       (if_instr2),
    .misalign_err   (misalign_err2)
  );

  // i_mem model: rom[i] = A000_0000 + i, 1024 words, upper address bits alias.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + ((a >> 2) % 32'd1024);
  endfunction

  always @(posedge clk) begin
    imem_instr  <= rom(imem_addr);
    imem_instr2 <= rom(imem_addr2);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the accepted stream is consecutive words from the last restart point.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  logic        exp_valid;
  logic        exp_mis;
  logic [31:0] next_pc;
  logic        mon_en = 1'b1;

  function automatic void refill();
    item_t it;
    while (exp_q.size() < 4) begin
      it.pc    = next_pc;
      it.instr = rom(next_pc);
      exp_q.push_back(it);
      next_pc  = next_pc + 32'd4;
    end
  endfunction

  function automatic void model_reset();
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
    exp_q.delete();
    next_pc   = 32'h0;
    refill();
  endfunction

  // Applies the inputs the DUT saw at the edge that just passed.
  function automatic void model_edge();
    exp_mis = redirect_valid && (redirect_pc % 4 != 0);
    if (redirect_valid) begin
      exp_valid = 1'b0;
      exp_q.delete();
      next_pc   = redirect_pc - (redirect_pc % 4);
    end else if (!stall) begin
      exp_valid = 1'b1;
    end
    refill();
  endfunction

  task automatic step(input logic s, input logic r, input logic [31:0] p);
    @(posedge clk);
    #1;
    model_edge();
    stall          = s;
    redirect_valid = r;
    redirect_pc    = p;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en) begin
      chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: queue empty, got pc %h", if_pc);
        end else begin
          chk("if_pc", if_pc, exp_q[0].pc);
          chk("if_instr", if_instr, exp_q[0].instr);
          if (!stall && !redirect_valid) void'(exp_q.pop_front());
        end
      end else begin
        chk("if_pc_idle", if_pc, 32'h0);
        chk("if_instr_idle", if_instr, 32'h0);
      end
    end
  end

  initial begin
    logic        s, r;
    logic [31:0] p;
    rst_n          = 1'b0;
    rst2_n         = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset_if_valid", {31'b0, if_valid}, 32'h0);
    chk("reset_imem_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch, then a 3-cycle stall while the third word is shown.
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    // Redirect to 0x40 while stalled with the hold buffer full.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 32'h40);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    // Misaligned redirect.
    step(0, 1, 32'h43);
    repeat (4) step(0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_if_valid", {31'b0, if_valid}, 32'h0);
        chk("midreset_imem_addr", imem_addr, 32'h0);
        chk("midreset_if_pc", if_pc, 32'h0);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        model_reset();
        rst_n = 1'b1;
      end
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 8);
      p = $urandom;
      if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) p[31:13] = '0;
      step(s, r, p);
    end
    step(0, 0, 0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    // Wrap-around instance.
    @(negedge clk);
    #2;
    chk("wrap_reset_valid", {31'b0, if_valid2}, 32'h0);
    chk("wrap_reset_addr", imem_addr2, WRAP_PC);
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p = WRAP_PC + 32'(4 * k);
      @(negedge clk);
      chk("wrap_if_valid", {31'b0, if_valid2}, 32'h1);
      chk("wrap_if_pc", if_pc2, p);
      chk("wrap_if_instr", if_instr2, rom(p));
    end
    chk("wrap_misalign", {31'b0, misalign_err2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
